// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks.
//   state_t   : spawner FSM state encoding
//   LFSR_W    : width of the pseudo-random generator
//   LFSR_TAPS : Galois feedback mask for the generator
//   clog2()   : ceiling log2, never less than 1 so it can size a port
package snake_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_QUERY = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR that advances on every clock edge.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads SEED (0 replaced by 1)
//   q     : current LFSR state
module lfsr_gen
    import snake_pkg::*;
#(
    parameter int               WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] q
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [WIDTH-1:0] RST_VAL = (SEED == '0) ? WIDTH'(1) : SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (q[0]) begin
            q <= (q >> 1) ^ TAPS;
        end else begin
            q <= q >> 1;
        end
    end

endmodule

// File: rtl/grid_spawner.sv
// Picks a random free cell inside the playfield border for a new item.
// A candidate is drawn from the LFSR, rejected if it lies in the margin,
// otherwise checked against the snake body through the occupancy port.
// After MAX_TRIES rejections the request ends with a fail pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for req
// ST_DRAW  | sampling a candidate cell from the LFSR
// ST_QUERY | occ_req held, waiting for occ_ack from the body logic
// ST_DONE  | one-cycle valid or fail pulse, then back to idle
//
//   clk, rst_n          : clock, asynchronous active-low reset
//   req                 : single-cycle request for a new position
//   busy                : request in progress (through the result pulse)
//   occ_req/col/row     : occupancy query toward the body logic
//   occ_ack, occ_hit    : query answer, occ_hit qualified by occ_ack
//   valid, fail         : one-cycle result pulses
//   col, row, x, y      : last accepted cell and its pixel origin
module grid_spawner
    import snake_pkg::*;
#(
    parameter int          COLS      = 64,
    parameter int          ROWS      = 48,
    parameter int          CELL      = 10,
    parameter int          MARGIN    = 2,
    parameter int          MAX_TRIES = 16,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          X_W       = 10,
    parameter int          Y_W       = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    output logic                     busy,
    output logic                     occ_req,
    output logic [clog2(COLS)-1:0]   occ_col,
    output logic [clog2(ROWS)-1:0]   occ_row,
    input  logic                     occ_ack,
    input  logic                     occ_hit,
    output logic                     valid,
    output logic                     fail,
    output logic [clog2(COLS)-1:0]   col,
    output logic [clog2(ROWS)-1:0]   row,
    output logic [X_W-1:0]           x,
    output logic [Y_W-1:0]           y
);

    localparam int CW = clog2(COLS);
    localparam int RW = clog2(ROWS);
    localparam int TW = clog2(MAX_TRIES + 1);

    localparam logic [CW-1:0]  C_LO     = CW'(MARGIN);
    localparam logic [CW-1:0]  C_HI     = CW'(COLS - 1 - MARGIN);
    localparam logic [RW-1:0]  R_LO     = RW'(MARGIN);
    localparam logic [RW-1:0]  R_HI     = RW'(ROWS - 1 - MARGIN);
    localparam logic [TW-1:0]  LAST_TRY = TW'(MAX_TRIES - 1);
    localparam logic [X_W-1:0] X_RST    = X_W'(MARGIN * CELL);
    localparam logic [Y_W-1:0] Y_RST    = Y_W'(MARGIN * CELL);
    localparam logic [X_W-1:0] CELL_X   = X_W'(CELL);
    localparam logic [Y_W-1:0] CELL_Y   = Y_W'(CELL);

    if ((COLS - 1) * CELL > (1 << X_W) - 1) begin : g_bad_x_w
        $error("grid_spawner: (COLS-1)*CELL does not fit in X_W bits");
    end
    if ((ROWS - 1) * CELL > (1 << Y_W) - 1) begin : g_bad_y_w
        $error("grid_spawner: (ROWS-1)*CELL does not fit in Y_W bits");
    end
    if (2 * MARGIN >= COLS || 2 * MARGIN >= ROWS) begin : g_bad_margin
        $error("grid_spawner: MARGIN leaves no usable cells");
    end
    if (CW + RW > LFSR_W) begin : g_bad_lfsr
        $error("grid_spawner: grid needs more random bits than the LFSR has");
    end
    if (MAX_TRIES < 1) begin : g_bad_tries
        $error("grid_spawner: MAX_TRIES must be at least 1");
    end

    logic [LFSR_W-1:0] lfsr;
    logic [CW-1:0]     cand_c;
    logic [RW-1:0]     cand_r;
    logic              cand_ok;
    logic [TW-1:0]     tries;
    logic              last_try;
    state_t            state;

    lfsr_gen #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    assign cand_c   = lfsr[CW-1:0];
    assign cand_r   = lfsr[CW+RW-1:CW];
    assign cand_ok  = (cand_c >= C_LO) && (cand_c <= C_HI) &&
                      (cand_r >= R_LO) && (cand_r <= R_HI);
    // The rejection being processed this cycle is the one that uses up the budget.
    assign last_try = (tries == LAST_TRY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tries   <= '0;
            busy    <= 1'b0;
            occ_req <= 1'b0;
            occ_col <= C_LO;
            occ_row <= R_LO;
            valid   <= 1'b0;
            fail    <= 1'b0;
            col     <= C_LO;
            row     <= R_LO;
            x       <= X_RST;
            y       <= Y_RST;
        end else begin
            valid <= 1'b0;
            fail  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_DRAW;
                        tries <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (cand_ok) begin
                        occ_col <= cand_c;
                        occ_row <= cand_r;
                        occ_req <= 1'b1;
                        state   <= ST_QUERY;
                    end else begin
                        tries <= tries + 1'b1;
                        if (last_try) begin
                            fail  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_QUERY: begin
                    if (occ_ack) begin
                        occ_req <= 1'b0;
                        if (occ_hit) begin
                            tries <= tries + 1'b1;
                            if (last_try) begin
                                fail  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                state <= ST_DRAW;
                            end
                        end else begin
                            col   <= occ_col;
                            row   <= occ_row;
                            x     <= X_W'(occ_col) * CELL_X;
                            y     <= Y_W'(occ_row) * CELL_Y;
                            valid <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    occ_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_spawner.sv
module tb_grid_spawner;

    localparam int MAXC = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic req = 1'b0;
    logic ack = 1'b0;
    logic hit = 1'b0;
    int   sel = 0;

    logic       a_busy, a_oreq, a_valid, a_fail;
    logic [5:0] a_ocol, a_orow, a_col, a_row;
    logic [9:0] a_x;
    logic [8:0] a_y;
    logic       b_busy, b_oreq, b_valid, b_fail;
    logic [5:0] b_ocol, b_orow, b_col, b_row;
    logic [9:0] b_x;
    logic [8:0] b_y;

    grid_spawner dut_a (
        .clk(clk), .rst_n(rst_n), .req(req && sel == 0), .busy(a_busy),
        .occ_req(a_oreq), .occ_col(a_ocol), .occ_row(a_orow),
        .occ_ack(ack && sel == 0), .occ_hit(hit), .valid(a_valid), .fail(a_fail),
        .col(a_col), .row(a_row), .x(a_x), .y(a_y)
    );

    grid_spawner #(.MAX_TRIES(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req && sel == 1), .busy(b_busy),
        .occ_req(b_oreq), .occ_col(b_ocol), .occ_row(b_orow),
        .occ_ack(ack && sel == 1), .occ_hit(hit), .valid(b_valid), .fail(b_fail),
        .col(b_col), .row(b_row), .x(b_x), .y(b_y)
    );

    wire       c_busy  = (sel == 1) ? b_busy  : a_busy;
    wire       c_oreq  = (sel == 1) ? b_oreq  : a_oreq;
    wire       c_valid = (sel == 1) ? b_valid : a_valid;
    wire       c_fail  = (sel == 1) ? b_fail  : a_fail;
    wire [5:0] c_ocol  = (sel == 1) ? b_ocol  : a_ocol;
    wire [5:0] c_orow  = (sel == 1) ? b_orow  : a_orow;
    wire [5:0] c_col   = (sel == 1) ? b_col   : a_col;
    wire [5:0] c_row   = (sel == 1) ? b_row   : a_row;
    wire [9:0] c_x     = (sel == 1) ? b_x     : a_x;
    wire [8:0] c_y     = (sel == 1) ? b_y     : a_y;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference random source: 16-bit Galois LFSR, mask 0xB400, one step per clock.
    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lstep(m_lfsr);
    end

    function automatic bit in_range(input logic [5:0] c, input logic [5:0] r);
        return (c >= 2) && (c <= 61) && (r >= 2) && (r <= 45);
    endfunction

    // Per-query responder plan and per-cycle expectations (cycle 0 = req cycle).
    int         q_dly [0:63];
    bit         q_hit [0:63];
    bit         e_valid [0:MAXC-1];
    bit         e_fail  [0:MAXC-1];
    bit         e_busy  [0:MAXC-1];
    bit         e_oreq  [0:MAXC-1];
    logic [5:0] e_qc    [0:MAXC-1];
    logic [5:0] e_qr    [0:MAXC-1];
    int         e_end;
    logic [5:0] e_col, e_row;
    logic [5:0] x_col [0:1];
    logic [5:0] x_row [0:1];

    task automatic model_run(input logic [15:0] l0, input int mt);
        logic [15:0] lf;
        logic [5:0]  c, r;
        int          t, tries, qi, d;
        bit          done;
        for (int i = 0; i < MAXC; i++) begin
            e_valid[i] = 0; e_fail[i] = 0; e_busy[i] = 0; e_oreq[i] = 0;
            e_qc[i] = '0; e_qr[i] = '0;
        end
        lf = lstep(l0); t = 1; tries = 0; qi = 0; done = 0; e_end = 1;
        e_col = '0; e_row = '0;
        while (!done) begin
            c = lf[5:0]; r = lf[11:6];
            e_busy[t] = 1;
            if (in_range(c, r)) begin
                d = q_dly[qi];
                for (int k = 1; k <= d + 1; k++) begin
                    e_busy[t+k] = 1; e_oreq[t+k] = 1; e_qc[t+k] = c; e_qr[t+k] = r;
                end
                for (int k = 0; k < d + 2; k++) lf = lstep(lf);
                t = t + d + 2;
                if (!q_hit[qi]) begin
                    e_valid[t] = 1; e_busy[t] = 1; e_end = t;
                    e_col = c; e_row = r; done = 1;
                end else begin
                    tries++;
                    if (tries == mt) begin
                        e_fail[t] = 1; e_busy[t] = 1; e_end = t; done = 1;
                    end
                end
                qi++;
            end else begin
                tries++; lf = lstep(lf); t++;
                if (tries == mt) begin
                    e_fail[t] = 1; e_busy[t] = 1; e_end = t; done = 1;
                end
            end
        end
    endtask

    task automatic run_txn(input int s, input int inject);
        int qi, wcnt;
        sel = s;
        @(negedge clk);
        model_run(m_lfsr, (s == 1) ? 8 : 16);
        req = 1'b1; qi = 0; wcnt = 0;
        for (int n = 1; n <= e_end + 3; n++) begin
            @(negedge clk);
            req = (inject > 0 && n == inject && n < e_end);
            if (c_oreq && qi < 64) begin
                if (wcnt >= q_dly[qi]) begin
                    ack = 1'b1; hit = q_hit[qi]; qi++; wcnt = 0;
                end else begin
                    ack = 1'b0; hit = 1'($urandom); wcnt++;
                end
            end else begin
                ack = 1'b0; hit = 1'($urandom);
            end
            chk("valid", c_valid, e_valid[n]);
            chk("fail", c_fail, e_fail[n]);
            chk("busy", c_busy, e_busy[n]);
            chk("occ_req", c_oreq, e_oreq[n]);
            if (e_oreq[n]) begin
                chk("occ_col", c_ocol, e_qc[n]);
                chk("occ_row", c_orow, e_qr[n]);
            end
            if (n == e_end) begin
                if (e_valid[n]) begin
                    x_col[s] = e_col; x_row[s] = e_row;
                end
                chk("col", c_col, x_col[s]);
                chk("row", c_row, x_row[s]);
                chk("x", c_x, 32'(x_col[s]) * 10);
                chk("y", c_y, 32'(x_row[s]) * 10);
            end
        end
        req = 1'b0; ack = 1'b0;
    endtask

    task automatic plan(input int dmax, input int hit_mode);
        for (int i = 0; i < 64; i++) begin
            q_dly[i] = (dmax < 0) ? -dmax : $urandom_range(0, dmax);
            q_hit[i] = (hit_mode == 1) ? 1'b1 :
                       (hit_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_x_a"}, a_x, 20);      chk({pfx, "_y_a"}, a_y, 20);
        chk({pfx, "_col_a"}, a_col, 2);   chk({pfx, "_row_a"}, a_row, 2);
        chk({pfx, "_valid_a"}, a_valid, 0); chk({pfx, "_busy_a"}, a_busy, 0);
        chk({pfx, "_oreq_a"}, a_oreq, 0); chk({pfx, "_fail_a"}, a_fail, 0);
        chk({pfx, "_x_b"}, b_x, 20);      chk({pfx, "_col_b"}, b_col, 2);
        chk({pfx, "_busy_b"}, b_busy, 0); chk({pfx, "_oreq_b"}, b_oreq, 0);
    endtask

    initial begin
        x_col[0] = 6'd2; x_row[0] = 6'd2; x_col[1] = 6'd2; x_row[1] = 6'd2;
        plan(0, 0);
        repeat (3) @(negedge clk);
        reset_checks("rst");
        rst_n = 1'b1;

        plan(0, 0);
        for (int i = 0; i < 1000; i++) run_txn(0, 0);

        for (int i = 0; i < 200; i++) begin
            plan(5, 2);
            run_txn(0, $urandom_range(0, 6));
        end

        plan(-5, 0);
        for (int i = 0; i < 20; i++) run_txn(0, 3);

        plan(0, 0);
        for (int i = 0; i < 10; i++) run_txn(1, 0);
        plan(0, 1);
        for (int i = 0; i < 5; i++) run_txn(1, $urandom_range(0, 4));
        plan(-2, 1);
        for (int i = 0; i < 3; i++) run_txn(1, 0);

        // Abort a query with reset while the body logic is still silent.
        sel = 0; ack = 1'b0;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        for (int n = 0; n < 60 && !a_oreq; n++) @(negedge clk);
        chk("mq_reach_query", a_oreq, 1);
        @(negedge clk);
        chk("mq_still_query", a_oreq, 1);
        #2 rst_n = 1'b0;
        #1;
        reset_checks("mq");
        ack = 1'b1; hit = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("mq_late_ack_busy", a_busy, 0);
            chk("mq_late_ack_valid", a_valid, 0);
            chk("mq_late_ack_oreq", a_oreq, 0);
        end
        ack = 1'b0;
        x_col[0] = 6'd2; x_row[0] = 6'd2; x_col[1] = 6'd2; x_row[1] = 6'd2;
        plan(0, 0);
        run_txn(0, 0);
        run_txn(1, 0);
        plan(3, 2);
        for (int i = 0; i < 5; i++) run_txn(0, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
